// File: rtl/note_detect_fsm_if.sv
// Read-side bus between the note detector, the FFT result memory and the bin-to-note ROM.
// The detector is the master: it issues addresses and consumes in-order read data.
interface note_detect_fsm_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0]   fft_address;
  logic                fft_read_enable;
  logic                fft_read_valid;
  logic [2*DATA_W-1:0] fft_data;
  logic [ADDR_W-1:0]   lut_address;
  logic [6:0]          lut_data;

  modport master (
    output fft_address, fft_read_enable, lut_address,
    input  fft_read_valid, fft_data, lut_data
  );

  modport slave (
    input  fft_address, fft_read_enable, lut_address,
    output fft_read_valid, fft_data, lut_data
  );
endinterface

// File: rtl/note_detect_fsm.sv
// Per-frame peak search over an FFT bin window, bin-to-note lookup and snap of the
// detected note to the nearest note allowed by a 12-bit scale mask.
module note_detect_fsm #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 9,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_fft_done,
  input  logic [11:0]         i_scale,
  input  logic [2*DATA_W-1:0] i_mag_threshold,
  note_detect_fsm_if.master   bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_note_valid,
  output logic [3:0]          o_note_name,
  output logic [2:0]          o_note_octave,
  output logic [3:0]          o_target_name,
  output logic [3:0]          o_shift,
  output logic [ADDR_W-1:0]   o_peak_bin,
  output logic [2*DATA_W-1:0] o_peak_mag
);
  localparam int MW = 2*DATA_W;
  localparam int N  = BIN_HI - BIN_LO + 1;
  localparam logic [ADDR_W:0]   N_CNT = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] A_LO  = ADDR_W'(BIN_LO);
  localparam logic [ADDR_W-1:0] A_HI  = ADDR_W'(BIN_HI);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, LUT_REQ, LUT_WAIT, SNAP, FINISH} state_t;

  typedef struct packed {
    logic              nv;
    logic [3:0]        name;
    logic [2:0]        oct;
    logic [3:0]        tgt;
    logic [3:0]        shift;
    logic [ADDR_W-1:0] bin;
    logic [MW-1:0]     mag;
  } result_t;

  state_t            r_state, w_state_n;
  logic [11:0]       r_scale;
  logic [MW-1:0]     r_thr;
  logic [ADDR_W-1:0] r_addr, r_lut_addr, r_rsp_bin, r_sq_bin;
  logic [ADDR_W:0]   r_rsp_cnt;
  logic              r_sq_vld;
  logic [MW-1:0]     r_sq_re, r_sq_im;
  result_t           r_res, r_out;
  logic              r_done;
  logic [2:0]        r_d;

  logic signed [DATA_W-1:0] w_re, w_im;
  logic signed [MW-1:0]     w_sq_re, w_sq_im;
  logic [MW-1:0]            w_mag, w_fin_mag;
  logic [ADDR_W-1:0]        w_fin_bin;
  logic                     w_accept, w_gt, w_all_rx, w_lut_ok;
  logic [3:0]               w_d4, w_dn, w_up;
  logic                     w_hit_dn, w_hit_up, w_snap_end;

  // Stage 1: squares of the accepted response; stage 2: sum and compare against the running max.
  assign w_re     = bus.fft_data[MW-1:DATA_W];
  assign w_im     = bus.fft_data[DATA_W-1:0];
  assign w_sq_re  = w_re * w_re;
  assign w_sq_im  = w_im * w_im;
  assign w_accept = bus.fft_read_valid && (r_state == SCAN || r_state == DRAIN) && (r_rsp_cnt != N_CNT);
  assign w_all_rx = (r_rsp_cnt == N_CNT);
  assign w_mag    = r_sq_re + r_sq_im;
  assign w_gt     = r_sq_vld && (w_mag > r_res.mag);

  // Forwarded max so DRAIN can decide in the same cycle the last compare lands.
  assign w_fin_mag = w_gt ? w_mag    : r_res.mag;
  assign w_fin_bin = w_gt ? r_sq_bin : r_res.bin;

  assign w_lut_ok = (bus.lut_data[3:0] <= 4'd11);

  // Mod-12 neighbours at distance d; 4-bit wrap keeps (name+12-d) exact since it stays below 16.
  assign w_d4       = {1'b0, r_d};
  assign w_dn       = (r_res.name >= w_d4) ? (r_res.name - w_d4) : (r_res.name + 4'd12 - w_d4);
  assign w_up       = (r_res.name >= 4'd12 - w_d4) ? (r_res.name + w_d4 - 4'd12) : (r_res.name + w_d4);
  assign w_hit_dn   = r_scale[w_dn];
  assign w_hit_up   = r_scale[w_up];
  assign w_snap_end = (r_scale == 12'd0) || w_hit_dn || w_hit_up || (r_d == 3'd6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:     if (i_fft_done) w_state_n = SCAN;
      SCAN:     if (r_addr == A_HI) w_state_n = DRAIN;
      DRAIN:    if (w_all_rx) w_state_n = (w_fin_mag < r_thr) ? FINISH : LUT_REQ;
      LUT_REQ:  w_state_n = LUT_WAIT;
      LUT_WAIT: w_state_n = w_lut_ok ? SNAP : FINISH;
      SNAP:     if (w_snap_end) w_state_n = FINISH;
      FINISH:   w_state_n = IDLE;
      default:  w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scale    <= '0;
      r_thr      <= '0;
      r_addr     <= '0;
      r_lut_addr <= '0;
      r_rsp_cnt  <= '0;
      r_rsp_bin  <= '0;
      r_sq_vld   <= 1'b0;
      r_sq_re    <= '0;
      r_sq_im    <= '0;
      r_sq_bin   <= '0;
      r_res      <= '0;
      r_out      <= '0;
      r_done     <= 1'b0;
      r_d        <= '0;
    end else begin
      r_done   <= (r_state == FINISH);
      r_sq_vld <= w_accept;
      if (w_accept) begin
        r_sq_re   <= w_sq_re;
        r_sq_im   <= w_sq_im;
        r_sq_bin  <= r_rsp_bin;
        r_rsp_cnt <= r_rsp_cnt + 1'b1;
        r_rsp_bin <= r_rsp_bin + 1'b1;
      end
      if (w_gt) begin
        r_res.mag <= w_mag;
        r_res.bin <= r_sq_bin;
      end
      case (r_state)
        IDLE: if (i_fft_done) begin
          r_scale   <= i_scale;
          r_thr     <= i_mag_threshold;
          r_res     <= '0;
          r_res.bin <= A_LO;
          r_addr    <= A_LO;
          r_rsp_cnt <= '0;
          r_rsp_bin <= A_LO;
        end
        SCAN:  if (r_addr != A_HI) r_addr <= r_addr + 1'b1;
        DRAIN: if (w_all_rx && w_fin_mag >= r_thr) r_lut_addr <= w_fin_bin;
        LUT_WAIT: begin
          r_d <= '0;
          if (w_lut_ok) begin
            r_res.name <= bus.lut_data[3:0];
            r_res.oct  <= bus.lut_data[6:4];
          end
        end
        SNAP: begin
          if (r_scale == 12'd0) begin
            r_res.nv    <= 1'b1;
            r_res.tgt   <= r_res.name;
            r_res.shift <= 4'd0;
          end else if (w_hit_dn) begin
            r_res.nv    <= 1'b1;
            r_res.tgt   <= w_dn;
            r_res.shift <= 4'd0 - w_d4;
          end else if (w_hit_up) begin
            r_res.nv    <= 1'b1;
            r_res.tgt   <= w_up;
            r_res.shift <= w_d4;
          end else begin
            r_d <= r_d + 1'b1;
          end
        end
        FINISH:  r_out <= r_res;
        default: ;
      endcase
    end
  end

  assign bus.fft_address     = r_addr;
  assign bus.fft_read_enable = (r_state == SCAN);
  assign bus.lut_address     = r_lut_addr;

  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;
  assign o_note_valid  = r_out.nv;
  assign o_note_name   = r_out.name;
  assign o_note_octave = r_out.oct;
  assign o_target_name = r_out.tgt;
  assign o_shift       = r_out.shift;
  assign o_peak_bin    = r_out.bin;
  assign o_peak_mag    = r_out.mag;
endmodule
